reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order retirement buffer at the far end of the rename/dispatch path. Accepts one renamed instr/cycle
//  (tag from rename's ROB allocator) and records completion from writeback. Retires the head in program
//  order, returning the superseded phys reg (commit_en/commit_old_preg) to rename's free list.
//  Also flushes entries younger than a mispredicted branch.
// PARAMETERS
//  PREG_WIDTH  7  physical register index width
//  ROB_WIDTH   4  tag width; DEPTH = 2**ROB_WIDTH entries (16)
// PORTS
//  clk                  in   1           clock, all state on posedge
//  reset                in   1           asynchronous, active-high
//  dispatch_valid       in   1           renamed instr present this cycle
//  dispatch_reg_write   in   1           instr writes a non-x0 arch reg
//  dispatch_is_branch   in   1           instr is a branch
//  dispatch_prd         in   PREG_WIDTH  new phys dest
//  dispatch_old_prd     in   PREG_WIDTH  previous mapping of rd; freed at commit
//  dispatch_rob_tag     in   ROB_WIDTH   tag from allocator; must equal tail
//  rob_ready            out  1           ROB not full; drives rename i_ready
//  wb_valid             in   1           execution result complete
//  wb_rob_tag           in   ROB_WIDTH   tag of completing instr
//  branch_mispredict    in   1           flush everything younger than mispredict_tag
//  mispredict_tag       in   ROB_WIDTH   tag of mispredicted branch (kept, not flushed)
//  retire_valid         out  1           one instr retired (registered)
//  retire_tag           out  ROB_WIDTH   tag of retired instr
//  commit_en            out  1           retired instr frees a preg (reg_write=1)
//  commit_old_preg      out  PREG_WIDTH  preg to free; 0 when commit_en=0
//  tag_error            out  1           sticky: accepted dispatch with tag != tail
// BEHAVIOUR
//  - Reset: head=tail=0, count=0 (ROB_WIDTH+1 bits), all entry valid/complete=0; rob_ready=1;
//    retire_valid=commit_en=tag_error=0, retire_tag=commit_old_preg=0. Async assert; an in-flight
//    program is simply dropped.
//  - Entry: {valid, complete, reg_write, is_branch, prd, old_prd}.
//  - rob_ready = (count != DEPTH); combinational from registered count only.
//  - Dispatch accepted iff dispatch_valid && rob_ready && !branch_mispredict. Write entry[tail], set
//    valid=1, complete=0. Then tail++ (mod DEPTH). If dispatch_rob_tag != tail, set tag_error (sticky);
//    still write at tail.
//  - Writeback: if wb_valid && entry[wb_rob_tag].valid, set complete=1. Invalid/already complete: no-op.
//  - Commit: if entry[head].valid && complete, retire it next edge: clear valid, head++.
//    Outputs are registered, valid one cycle after the edge that retires: retire_valid=1, retire_tag=old
//    head, commit_en=reg_write, commit_old_preg = reg_write ? old_prd : 0. Max one retire per cycle.
//  - Wb to head and head commit same cycle: commit waits a cycle (complete is seen registered).
//  - Flush (branch_mispredict): invalidate entries (mispredict_tag+1 .. tail-1), tail = mispredict_tag+1,
//    count = ((mispredict_tag - head) mod DEPTH) + 1, minus 1 if head commits same cycle.
//    This covers the branch being the last entry of a full ROB (count=DEPTH). Same-cycle dispatch dropped;
//    same-cycle wb to a flushed tag ignored; wb to surviving tags applied. Head-is-branch commit allowed.
//  - count update otherwise: +accept -retire, both may occur (net 0). Dispatch while full is dropped.
//  - Wrap-around: all pointers mod DEPTH. Full/empty distinguished only by count.
// STRUCTURE
//  - rob_pkg: rob_entry_t struct; localparam DEPTH; ptr/count typedefs shared with rob_allocator.
//  - Single module. Entry array + head/tail/count regs + output regs. No sub-module: the pointer logic
//    is too small to justify one.
// TESTING
//  1 reset mid-run with 5 entries: outputs 0 same cycle, rob_ready=1, count=0, no retire afterwards.
//  2 dispatch tags 0..15 (reg_write=1, old_prd=20+i) -> rob_ready=0 after 16th; 17th dropped.
//    Wb all, then commits: old_preg 20..35 in order, one/cycle.
//  3 wb out of order (tag 2, then 1, then 0) -> no retire until tag 0 done; then tags 0,1,2 on 3 cycles.
//  4 reg_write=0 entry (store, old_prd=9) -> retire_valid=1, commit_en=0, commit_old_preg=0.
//  5 tags 0..5, branch at 2, mispredict_tag=2 -> tail=3, count=3; wb to tag 4 ignored; next dispatch
//    tag 3 accepted, tag_error stays 0.
//  6 wrap: head=tail=14, fill 16, flush at tag 13 (last) -> count=16 kept. Also dispatch tag 7 when
//    tail=3 -> tag_error=1 and stays set.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: entry layout plus pointer/count widths used by
// the ROB and the rename-side tag allocator.
package rob_pkg;

  localparam int PREG_W = 7;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 1 << TAG_W;

  typedef logic [TAG_W-1:0]  ptr_t;
  typedef logic [TAG_W:0]    count_t;
  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    logic  valid;
    logic  complete;
    logic  reg_write;
    logic  is_branch;
    preg_t prd;
    preg_t old_prd;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: records dispatched instructions, marks them complete
// on writeback, retires the head in program order and flushes on a mispredict.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int PREG_WIDTH = PREG_W,
  parameter int ROB_WIDTH  = TAG_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dispatch_valid,
  input  logic                  dispatch_reg_write,
  input  logic                  dispatch_is_branch,
  input  logic [PREG_WIDTH-1:0] dispatch_prd,
  input  logic [PREG_WIDTH-1:0] dispatch_old_prd,
  input  logic [ROB_WIDTH-1:0]  dispatch_rob_tag,
  output logic                  rob_ready,
  input  logic                  wb_valid,
  input  logic [ROB_WIDTH-1:0]  wb_rob_tag,
  input  logic                  branch_mispredict,
  input  logic [ROB_WIDTH-1:0]  mispredict_tag,
  output logic                  retire_valid,
  output logic [ROB_WIDTH-1:0]  retire_tag,
  output logic                  commit_en,
  output logic [PREG_WIDTH-1:0] commit_old_preg,
  output logic                  tag_error
);

  rob_entry_t       entries [DEPTH];
  ptr_t             head;
  ptr_t             tail;
  count_t           count;
  logic             accept;
  logic             commit_fire;
  ptr_t             mis_next;
  ptr_t             mis_age;
  count_t           flush_count;
  logic [DEPTH-1:0] flush_mask;

  assign rob_ready   = (count != count_t'(DEPTH));
  assign accept      = dispatch_valid && rob_ready && !branch_mispredict;
  assign commit_fire = entries[head].valid && entries[head].complete;
  assign mis_next    = ptr_t'(mispredict_tag) + ptr_t'(1);
  assign mis_age     = ptr_t'(mispredict_tag) - head;
  assign flush_count = count_t'({1'b0, mis_age}) + count_t'(1) - count_t'(commit_fire);

  // Age relative to head orders entries by program order, so "younger than the
  // branch" is simply a larger age; this also holds when the ROB is full.
  always_comb begin
    flush_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      flush_mask[i] = branch_mispredict && ((ptr_t'(i) - head) > mis_age);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      retire_valid    <= 1'b0;
      retire_tag      <= '0;
      commit_en       <= 1'b0;
      commit_old_preg <= '0;
      tag_error       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_mask[i]) begin
          entries[i].valid    <= 1'b0;
          entries[i].complete <= 1'b0;
        end else if (wb_valid && (ptr_t'(wb_rob_tag) == ptr_t'(i)) && entries[i].valid) begin
          entries[i].complete <= 1'b1;
        end
      end

      if (commit_fire) begin
        entries[head].valid    <= 1'b0;
        entries[head].complete <= 1'b0;
        head                   <= head + ptr_t'(1);
      end

      if (accept) begin
        entries[tail] <= '{valid:     1'b1,
                           complete:  1'b0,
                           reg_write: dispatch_reg_write,
                           is_branch: dispatch_is_branch,
                           prd:       preg_t'(dispatch_prd),
                           old_prd:   preg_t'(dispatch_old_prd)};
        if (ptr_t'(dispatch_rob_tag) != tail) begin
          tag_error <= 1'b1;
        end
      end

      if (branch_mispredict) begin
        tail  <= mis_next;
        count <= flush_count;
      end else begin
        if (accept) begin
          tail <= tail + ptr_t'(1);
        end
        count <= count + count_t'(accept) - count_t'(commit_fire);
      end

      // Retire outputs describe the entry retired at this edge.
      retire_valid    <= commit_fire;
      retire_tag      <= commit_fire ? ROB_WIDTH'(head) : '0;
      commit_en       <= commit_fire && entries[head].reg_write;
      commit_old_preg <= (commit_fire && entries[head].reg_write)
                         ? PREG_WIDTH'(entries[head].old_prd) : '0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: fill/drain, out-of-order
// writeback, stores, async reset, mispredict flush, wrap-around and tag errors.
module tb_reorder_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       dispatch_valid;
  logic       dispatch_reg_write;
  logic       dispatch_is_branch;
  logic [6:0] dispatch_prd;
  logic [6:0] dispatch_old_prd;
  logic [3:0] dispatch_rob_tag;
  logic       rob_ready;
  logic       wb_valid;
  logic [3:0] wb_rob_tag;
  logic       branch_mispredict;
  logic [3:0] mispredict_tag;
  logic       retire_valid;
  logic [3:0] retire_tag;
  logic       commit_en;
  logic [6:0] commit_old_preg;
  logic       tag_error;

  int         check_count = 0;
  int         fail_count  = 0;
  logic [6:0] exp_old [16];

  reorder_buffer dut (
    .clk                (clk),
    .reset              (reset),
    .dispatch_valid     (dispatch_valid),
    .dispatch_reg_write (dispatch_reg_write),
    .dispatch_is_branch (dispatch_is_branch),
    .dispatch_prd       (dispatch_prd),
    .dispatch_old_prd   (dispatch_old_prd),
    .dispatch_rob_tag   (dispatch_rob_tag),
    .rob_ready          (rob_ready),
    .wb_valid           (wb_valid),
    .wb_rob_tag         (wb_rob_tag),
    .branch_mispredict  (branch_mispredict),
    .mispredict_tag     (mispredict_tag),
    .retire_valid       (retire_valid),
    .retire_tag         (retire_tag),
    .commit_en          (commit_en),
    .commit_old_preg    (commit_old_preg),
    .tag_error          (tag_error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expected);
    check_count++;
    if (got !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, expected);
    end
  endtask

  // Drives one cycle of inputs across a posedge, returns 1 time unit after it.
  task automatic applyStimulus(input logic dv, input logic rw, input logic br,
                               input logic [6:0] old, input logic [3:0] tag,
                               input logic wbv, input logic [3:0] wbt,
                               input logic mis, input logic [3:0] mtag);
    dispatch_valid     = dv;
    dispatch_reg_write = rw;
    dispatch_is_branch = br;
    dispatch_old_prd   = old;
    dispatch_prd       = old + 7'd1;
    dispatch_rob_tag   = tag;
    wb_valid           = wbv;
    wb_rob_tag         = wbt;
    branch_mispredict  = mis;
    mispredict_tag     = mtag;
    @(posedge clk);
    #1;
    dispatch_valid     = 1'b0;
    dispatch_reg_write = 1'b0;
    dispatch_is_branch = 1'b0;
    dispatch_old_prd   = '0;
    dispatch_prd       = '0;
    dispatch_rob_tag   = '0;
    wb_valid           = 1'b0;
    wb_rob_tag         = '0;
    branch_mispredict  = 1'b0;
    mispredict_tag     = '0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
  endtask

  task automatic fillEntries(input logic [3:0] start, input int n, input logic [6:0] base,
                             input logic use_br, input logic [3:0] br_tag);
    for (int k = 0; k < n; k++) begin
      logic [3:0] t;
      t = start + 4'(k);
      exp_old[t] = base + 7'(k);
      applyStimulus(1'b1, 1'b1, use_br && (t == br_tag), base + 7'(k), t,
                    1'b0, 4'd0, 1'b0, 4'd0);
    end
  endtask

  // Completes n entries in program order from start; each retires one cycle later.
  task automatic drainEntries(input logic [3:0] start, input int n);
    logic [3:0] t;
    logic [3:0] prev;
    for (int k = 0; k < n; k++) begin
      t = start + 4'(k);
      applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 4'd0, 1'b1, t, 1'b0, 4'd0);
      if (k == 0) begin
        checkOutput("drain_first_idle", retire_valid, 0);
      end else begin
        prev = t - 4'd1;
        checkOutput("drain_valid", retire_valid, 1);
        checkOutput("drain_tag", retire_tag, prev);
        checkOutput("drain_en", commit_en, 1);
        checkOutput("drain_old", commit_old_preg, exp_old[prev]);
      end
    end
    prev = start + 4'(n - 1);
    idle();
    checkOutput("drain_last_valid", retire_valid, 1);
    checkOutput("drain_last_tag", retire_tag, prev);
    checkOutput("drain_last_old", commit_old_preg, exp_old[prev]);
    idle();
    checkOutput("drain_done", retire_valid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    dispatch_valid = 1'b0; dispatch_reg_write = 1'b0; dispatch_is_branch = 1'b0;
    dispatch_prd = '0; dispatch_old_prd = '0; dispatch_rob_tag = '0;
    wb_valid = 1'b0; wb_rob_tag = '0; branch_mispredict = 1'b0; mispredict_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_retire_valid", retire_valid, 0);
    checkOutput("rst_retire_tag", retire_tag, 0);
    checkOutput("rst_commit_en", commit_en, 0);
    checkOutput("rst_old_preg", commit_old_preg, 0);
    checkOutput("rst_rob_ready", rob_ready, 1);
    checkOutput("rst_tag_error", tag_error, 0);
    reset = 1'b0;

    // Fill to capacity, overflow dispatch dropped, then drain in order.
    fillEntries(4'd0, 15, 7'd20, 1'b0, 4'd0);
    checkOutput("fill15_ready", rob_ready, 1);
    fillEntries(4'd15, 1, 7'd35, 1'b0, 4'd0);
    checkOutput("fill16_ready", rob_ready, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 7'd99, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    checkOutput("overflow_ready", rob_ready, 0);
    checkOutput("overflow_tag_error", tag_error, 0);
    drainEntries(4'd0, 16);
    checkOutput("drained_ready", rob_ready, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0);
    idle();
    checkOutput("overflow_dropped", retire_valid, 0);

    // Out-of-order writeback: nothing retires until the head completes.
    fillEntries(4'd0, 3, 7'd50, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 4'd0, 1'b1, 4'd2, 1'b0, 4'd0);
    checkOutput("ooo_wb2", retire_valid, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 4'd0, 1'b1, 4'd1, 1'b0, 4'd0);
    checkOutput("ooo_wb1", retire_valid, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0);
    checkOutput("ooo_wb0", retire_valid, 0);
    for (int k = 0; k < 3; k++) begin
      idle();
      checkOutput("ooo_valid", retire_valid, 1);
      checkOutput("ooo_tag", retire_tag, k);
      checkOutput("ooo_old", commit_old_preg, 50 + k);
    end
    idle();
    checkOutput("ooo_done", retire_valid, 0);

    // Store-like entry: retires without freeing a preg.
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd9, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 4'd0, 1'b1, 4'd3, 1'b0, 4'd0);
    idle();
    checkOutput("store_valid", retire_valid, 1);
    checkOutput("store_tag", retire_tag, 3);
    checkOutput("store_commit_en", commit_en, 0);
    checkOutput("store_old_preg", commit_old_preg, 0);
    checkOutput("store_tag_error", tag_error, 0);

    // Async reset while an entry is retiring and others are complete.
    fillEntries(4'd4, 5, 7'd120, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 4'd0, 1'b1, 4'd4, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 4'd0, 1'b1, 4'd5, 1'b0, 4'd0);
    checkOutput("pre_reset_valid", retire_valid, 1);
    checkOutput("pre_reset_old", commit_old_preg, 120);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_retire_valid", retire_valid, 0);
    checkOutput("async_commit_en", commit_en, 0);
    checkOutput("async_old_preg", commit_old_preg, 0);
    checkOutput("async_ready", rob_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle();
      checkOutput("post_reset_quiet", retire_valid, 0);
    end

    // Mispredict at tag 2 flushes 3..5; same-cycle dispatch and wb to 4 dropped.
    fillEntries(4'd0, 6, 7'd60, 1'b1, 4'd2);
    checkOutput("pre_flush_tag_error", tag_error, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 7'd99, 4'd6, 1'b1, 4'd4, 1'b1, 4'd2);
    checkOutput("flush_ready", rob_ready, 1);
    checkOutput("flush_no_retire", retire_valid, 0);
    fillEntries(4'd3, 1, 7'd70, 1'b0, 4'd0);
    checkOutput("post_flush_tag_error", tag_error, 0);
    fillEntries(4'd4, 11, 7'd80, 1'b0, 4'd0);
    checkOutput("flush_count_15_ready", rob_ready, 1);
    fillEntries(4'd15, 1, 7'd91, 1'b0, 4'd0);
    checkOutput("flush_count_16_ready", rob_ready, 0);
    checkOutput("flush_fill_tag_error", tag_error, 0);
    drainEntries(4'd0, 16);

    // Move head/tail to 14, then flush a full ROB at its last entry (tag 13).
    fillEntries(4'd0, 14, 7'd10, 1'b0, 4'd0);
    drainEntries(4'd0, 14);
    fillEntries(4'd14, 16, 7'd100, 1'b1, 4'd13);
    checkOutput("wrap_full_ready", rob_ready, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 7'd99, 4'd5, 1'b0, 4'd0, 1'b1, 4'd13);
    checkOutput("wrap_flush_ready", rob_ready, 0);
    checkOutput("wrap_flush_tag_error", tag_error, 0);
    drainEntries(4'd14, 16);

    // Tail is 3 after five dispatches from 14; a tag of 7 is flagged and sticks.
    fillEntries(4'd14, 5, 7'd40, 1'b0, 4'd0);
    checkOutput("tag_ok", tag_error, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 7'd5, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0);
    checkOutput("tag_error_set", tag_error, 1);
    idle();
    checkOutput("tag_error_sticky", tag_error, 1);
    fillEntries(4'd4, 1, 7'd6, 1'b0, 4'd0);
    checkOutput("tag_error_still", tag_error, 1);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
